// File: rtl/dev_timer.sv
// dev_timer: memory-mapped countdown timer on the data-side system bus.
//
// Sits behind the byte-enable unit. It takes the word address, the per-byte
// enables and the lane-aligned write data from that unit. It returns raw
// 32-bit read data and raises a level interrupt toward CP0 when the count
// expires.
//
// Register map (only addr[3:2] is decoded):
//   0x0 CTRL     [0] EN, [2:1] MODE (01 = auto-reload, all other values = one-shot),
//                [3] IM (interrupt mask). Bits [31:4] are not stored and read 0.
//   0x4 PRESET   reload value, copied into COUNT in the LOAD state
//   0x8 COUNT    read-only current count
//   0xC PRESCALE 8-bit prescaler, present only with TIMER_PRESCALE_EN;
//                without it, 0xC reads 0 and writes to it are dropped
//
// Optional build macro: TIMER_PRESCALE_EN (adds PRESCALE and a tick counter).
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   addr     bus address, only [3:2] used
//   byte_en  per-byte write enables; 4'b0000 = no write
//   wdata    lane-aligned write data
//   rdata    combinational read data (register value before the edge)
//   irq      interrupt request = flag & IM
module dev_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL     = 2'd0;
  localparam logic [1:0] A_PRESET   = 2'd1;
  localparam logic [1:0] A_COUNT    = 2'd2;
  localparam logic [1:0] A_PRESCALE = 2'd3;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic [1:0]  sel;
  logic        wr;
  logic        step;
  logic        auto_reload;

`ifdef TIMER_PRESCALE_EN
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  tick_q, tick_d;
`endif

  // Only the word index inside this device's window matters.
  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign sel         = addr[3:2];
  assign wr          = |byte_en;
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // Replace the enabled byte lanes and keep the other lanes.
  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  // A CNT cycle counts (or checks expiry) only when the prescaler fires.
`ifdef TIMER_PRESCALE_EN
  assign step = (tick_q == prescale_q);
`else
  assign step = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
`ifdef TIMER_PRESCALE_EN
    prescale_d = prescale_q;
    tick_d     = tick_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
        tick_d  = 8'd0;
`endif
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;        // COUNT freezes where it is
        end else if (step) begin
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else begin
            state_d = S_INT;
            flag_d  = 1'b1;
          end
`ifdef TIMER_PRESCALE_EN
          tick_d = 8'd0;
`endif
        end else begin
`ifdef TIMER_PRESCALE_EN
          tick_d = tick_q + 8'd1;
`endif
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        // Auto-reload keeps EN so IDLE goes straight to LOAD again, and the
        // flag becomes a one-cycle pulse. One-shot stops and latches the flag.
        if (auto_reload) flag_d    = 1'b0;
        else             ctrl_d[0] = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes are applied last so they override the FSM in the same cycle.
    if (wr) begin
      case (sel)
        A_CTRL: begin
          if (byte_en[0]) ctrl_d = wdata[3:0];
          flag_d = 1'b0;
        end
        A_PRESET: begin
          preset_d = merge(preset_q, wdata, byte_en);
          flag_d   = 1'b0;
        end
        A_PRESCALE: begin
`ifdef TIMER_PRESCALE_EN
          if (byte_en[0]) prescale_d = wdata[7:0];
`endif
        end
        default: ;                 // COUNT is read-only
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= 8'd0;
      tick_q     <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= prescale_d;
      tick_q     <= tick_d;
`endif
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (sel)
      A_CTRL:     rdata = {28'd0, ctrl_q};
      A_PRESET:   rdata = preset_q;
      A_COUNT:    rdata = count_q;
      A_PRESCALE: begin
`ifdef TIMER_PRESCALE_EN
        rdata = {24'd0, prescale_q};
`else
        rdata = 32'd0;
`endif
      end
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_dev_timer.sv
// Directed bench for dev_timer. Inputs change at the falling edge. Outputs
// are sampled 1 ns or more after the rising edge.
module tb_dev_timer;
  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int tests;
  int fails;

  dev_timer dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .byte_en (byte_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    chk(rdata, exp, tag);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    chk({31'd0, irq}, {31'd0, exp}, tag);
  endtask

  // The write lands on the next rising edge. The task returns 1 ns after it.
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    addr    = a;
    byte_en = be;
    wdata   = d;
    @(posedge clk);
    #1;
    byte_en = 4'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    addr    = 32'd0;
    byte_en = 4'd0;
    wdata   = 32'd0;
    tick(2);
    reset = 1'b0;

    // reset state
    rd(32'h0, 32'h0, "rst_ctrl");
    rd(32'h4, 32'h0, "rst_preset");
    rd(32'h8, 32'h0, "rst_count");
    rd(32'hC, 32'h0, "rst_0xC");
    chk_irq(1'b0, "rst_irq");

    // byte merge, read-only COUNT, unstored CTRL bits
    wr(32'h4, 4'b0011, 32'h12345678);
    rd(32'h4, 32'h00005678, "merge_lo");
    wr(32'h4, 4'b1100, 32'hAABB0000);
    rd(32'h4, 32'hAABB5678, "merge_hi");
    wr(32'h8, 4'b1111, 32'hFFFFFFFF);
    rd(32'h8, 32'h0, "count_ro");
    wr(32'h0, 4'b1111, 32'hFFFFFFF0);
    rd(32'h0, 32'h0, "ctrl_upper");
`ifndef TIMER_PRESCALE_EN
    wr(32'hC, 4'b1111, 32'hFFFFFFFF);
    rd(32'hC, 32'h0, "absent_0xC");
`endif

    // one-shot, PRESET=5, EN written at E0
    wr(32'h4, 4'b1111, 32'd5);
    wr(32'h0, 4'b0001, 32'h9);         // E0
    tick(2);                           // after E2
    rd(32'h8, 32'd5, "os_count_e2");
    tick(5);                           // after E7
    rd(32'h8, 32'd0, "os_count_e7");
    chk_irq(1'b0, "os_irq_e7");
    tick(1);                           // after E8
    chk_irq(1'b1, "os_irq_e8");
    tick(1);                           // after E9
    rd(32'h0, 32'h8, "os_en_cleared");
    chk_irq(1'b1, "os_irq_e9");
    tick(3);
    chk_irq(1'b1, "os_irq_held");
    rd(32'h8, 32'd0, "os_no_wrap");
    wr(32'h0, 4'b0001, 32'h8);
    chk_irq(1'b0, "os_ctrl_clr");

    // PRESET=0: INT at E3; PRESET write clears the flag
    wr(32'h4, 4'b1111, 32'd0);
    wr(32'h0, 4'b0001, 32'h9);         // E0
    tick(2);
    chk_irq(1'b0, "p0_irq_e2");
    tick(1);
    chk_irq(1'b1, "p0_irq_e3");
    tick(1);
    rd(32'h0, 32'h8, "p0_en_cleared");
    wr(32'h4, 4'b0001, 32'd0);
    chk_irq(1'b0, "p0_preset_clr");

    // CPU write of EN in the INT cycle wins over the one-shot EN clear
    wr(32'h0, 4'b0001, 32'h9);         // P0
    tick(3);                           // after P3: INT
    chk_irq(1'b1, "pri_irq_p3");
    wr(32'h0, 4'b0001, 32'h9);         // P4: INT edge
    rd(32'h0, 32'h9, "pri_en_kept");
    chk_irq(1'b0, "pri_irq_clr");
    tick(3);                           // after P7: INT again
    chk_irq(1'b1, "pri_reload_irq");
    wr(32'h0, 4'b0001, 32'h0);         // P8
    rd(32'h0, 32'h0, "pri_stop");
    chk_irq(1'b0, "pri_stop_irq");

    // auto-reload, PRESET=3: period 7
    wr(32'h4, 4'b1111, 32'd3);
    wr(32'h0, 4'b0001, 32'hB);         // E0
    tick(5);                           // after E5
    rd(32'h8, 32'd0, "ar_count_e5");
    chk_irq(1'b0, "ar_irq_e5");
    tick(1);                           // after E6
    chk_irq(1'b1, "ar_pulse1");
    tick(1);                           // after E7
    chk_irq(1'b0, "ar_pulse1_end");
    rd(32'h0, 32'hB, "ar_en_kept");
    tick(2);                           // after E9
    rd(32'h8, 32'd3, "ar_reload");
    tick(4);                           // after E13
    chk_irq(1'b1, "ar_pulse2");
    tick(1);                           // after E14
    chk_irq(1'b0, "ar_pulse2_end");
    wr(32'h0, 4'b0001, 32'h3);         // F0, IM=0
    tick(1);                           // after F1
    rd(32'h8, 32'd3, "ar_nim_f1");
    tick(4);                           // after F5: INT
    rd(32'h8, 32'd0, "ar_nim_f5");
    chk_irq(1'b0, "ar_nim_irq");
    tick(3);                           // after F8
    rd(32'h8, 32'd3, "ar_nim_cycle");
    chk_irq(1'b0, "ar_nim_irq2");
    wr(32'h0, 4'b0001, 32'h0);
    tick(2);

    // freeze, re-enable, mid-count PRESET write, reset mid-count
    wr(32'h4, 4'b1111, 32'd10);
    wr(32'h0, 4'b0001, 32'h1);         // H0
    tick(5);                           // after H5
    rd(32'h8, 32'd7, "fr_count_h5");
    wr(32'h0, 4'b0001, 32'h0);         // H6
    rd(32'h8, 32'd6, "fr_count_h6");
    tick(1);
    rd(32'h8, 32'd6, "fr_hold1");
    tick(3);
    rd(32'h8, 32'd6, "fr_hold2");
    wr(32'h0, 4'b0001, 32'h1);         // J0
    tick(1);                           // after J1: LOAD
    rd(32'h8, 32'd6, "fr_load");
    tick(1);                           // after J2
    rd(32'h8, 32'd10, "fr_reloaded");
    wr(32'h4, 4'b1111, 32'd7);         // J3
    rd(32'h8, 32'd9, "mid_preset_j3");
    tick(1);
    rd(32'h8, 32'd8, "mid_preset_j4");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd(32'h0, 32'h0, "mrst_ctrl");
    rd(32'h4, 32'h0, "mrst_preset");
    rd(32'h8, 32'h0, "mrst_count");
    chk_irq(1'b0, "mrst_irq");
    reset = 1'b0;
    tick(3);
    rd(32'h8, 32'h0, "mrst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
